// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one registered write port among NREQ requesters.
// Grant is combinational; the output slot refills on the cycle it drains.
module wb_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 6,
    parameter int SW   = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        out_addr,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_src
);

    logic [SW-1:0]   r_ptr;
    logic            r_valid;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [SW-1:0]   r_src;

    logic [NREQ-1:0] w_lomask;
    logic [NREQ-1:0] w_upper;
    logic [NREQ-1:0] w_scan;
    logic [NREQ-1:0] w_gnt;
    logic [SW-1:0]   w_win;
    logic [SW-1:0]   w_ptr_nxt;
    logic            w_accept;
    logic            w_any;
    logic            w_hs;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;

    assign w_accept = ~r_valid | out_ready;
    assign w_any    = |req_valid;
    assign w_hs     = w_accept & w_any & ~RST;

    // Requests at or above ptr take priority; otherwise wrap to the lowest index.
    always_comb begin
        w_lomask = (NREQ'(1) << r_ptr) - NREQ'(1);
        w_upper  = req_valid & ~w_lomask;
        w_scan   = (|w_upper) ? w_upper : req_valid;
        w_win    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_scan[i]) begin
                w_win = SW'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_win == SW'(NREQ - 1)) ? '0 : w_win + SW'(1);

    always_comb begin
        w_gnt  = '0;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == SW'(i)) begin
                w_gnt[i] = w_hs;
                w_addr   = req_addr[i*AW +: AW];
                w_data   = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_hs) begin
            r_ptr   <= w_ptr_nxt;
            r_valid <= 1'b1;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_src   <= w_win;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign req_ready = w_gnt;
    assign out_valid = r_valid;
    assign out_addr  = r_addr;
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed vector table, NREQ=3 wrap sequence,
// and randomized traffic against a queue-free round-robin reference model.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int SW = 2;

    logic              CLK;
    logic              RST;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;

    logic              RST3;
    logic [2:0]        v3;
    logic [2:0]        rdy3;
    logic [3*AW-1:0]   addr3;
    logic [3*DW-1:0]   data3;
    logic              ov3;
    logic              ordy3;
    logic [AW-1:0]     oa3;
    logic [DW-1:0]     od3;
    logic [1:0]        os3;

    int checks   = 0;
    int failures = 0;

    wb_rr_arbiter #(.NREQ(N), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_src(out_src)
    );

    wb_rr_arbiter #(.NREQ(3), .DW(DW), .AW(AW)) dut3 (
        .CLK(CLK), .RST(RST3),
        .req_valid(v3), .req_ready(rdy3),
        .req_addr(addr3), .req_data(data3),
        .out_valid(ov3), .out_ready(ordy3),
        .out_addr(oa3), .out_data(od3), .out_src(os3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: spec-level state, winner found by modular scan.
    int            m_ptr;
    bit            m_v;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_win;
    bit            m_hs;
    logic [N-1:0]  m_rdy;

    task automatic model_comb();
        int idx;
        m_win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (m_win < 0 && req_valid[idx]) m_win = idx;
        end
        m_hs  = (m_win >= 0) && (!m_v || out_ready) && !RST;
        m_rdy = m_hs ? (N'(1) << m_win) : '0;
    endtask

    task automatic model_update();
        if (RST) begin
            m_ptr = 0; m_v = 0; m_addr = '0; m_data = '0; m_src = 0;
        end else if (m_hs) begin
            m_v    = 1;
            m_addr = req_addr[m_win*AW +: AW];
            m_data = req_data[m_win*DW +: DW];
            m_src  = m_win;
            m_ptr  = (m_win + 1) % N;
        end else if (m_v && out_ready) begin
            m_v = 0;
        end
    endtask

    typedef struct {
        bit       rst;
        logic [3:0] vld;
        bit       ordy;
        logic [3:0] rdy;
        bit       co;
        bit       ov;
        int       src;
        bit       zero;
    } vec_t;

    vec_t          tbl[25];
    logic [AW-1:0] pa[4];
    logic [DW-1:0] pd[4];

    initial begin
        RST = 1'b1; req_valid = '0; out_ready = 1'b1;
        req_addr = '0; req_data = '0;
        RST3 = 1'b1; v3 = '0; ordy3 = 1'b1;
        addr3 = {6'd3, 6'd2, 6'd1};
        data3 = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        m_ptr = 0; m_v = 0; m_addr = '0; m_data = '0; m_src = 0;

        pa = '{6'd10, 6'd11, 6'd5, 6'd13};
        pd = '{32'h1000_0000, 32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333};
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = pa[i];
            req_data[i*DW +: DW] = pd[i];
        end

        tbl[0]  = '{1, 4'b1111, 1, 4'b0000, 0, 0, 0, 1};
        tbl[1]  = '{1, 4'b1111, 1, 4'b0000, 1, 0, 0, 1};
        tbl[2]  = '{0, 4'b0100, 1, 4'b0100, 1, 0, 0, 1};
        tbl[3]  = '{0, 4'b0000, 1, 4'b0000, 1, 1, 2, 0};
        tbl[4]  = '{0, 4'b0000, 1, 4'b0000, 1, 0, 2, 0};
        tbl[5]  = '{1, 4'b0000, 1, 4'b0000, 1, 0, 2, 0};
        tbl[6]  = '{0, 4'b1111, 1, 4'b0001, 1, 0, 0, 1};
        tbl[7]  = '{0, 4'b1111, 1, 4'b0010, 1, 1, 0, 0};
        tbl[8]  = '{0, 4'b1111, 1, 4'b0100, 1, 1, 1, 0};
        tbl[9]  = '{0, 4'b1111, 1, 4'b1000, 1, 1, 2, 0};
        tbl[10] = '{0, 4'b1111, 1, 4'b0001, 1, 1, 3, 0};
        tbl[11] = '{0, 4'b1111, 1, 4'b0010, 1, 1, 0, 0};
        for (int r = 12; r <= 16; r++)
            tbl[r] = '{0, 4'b1111, 0, 4'b0000, 1, 1, 1, 0};
        tbl[17] = '{0, 4'b1111, 1, 4'b0100, 1, 1, 1, 0};
        tbl[18] = '{0, 4'b0010, 1, 4'b0010, 1, 1, 2, 0};
        tbl[19] = '{0, 4'b1111, 1, 4'b0100, 1, 1, 1, 0};
        tbl[20] = '{0, 4'b0010, 1, 4'b0010, 1, 1, 2, 0};
        tbl[21] = '{1, 4'b1111, 1, 4'b0000, 1, 1, 1, 0};
        tbl[22] = '{0, 4'b1110, 1, 4'b0010, 1, 0, 0, 1};
        tbl[23] = '{0, 4'b0000, 1, 4'b0000, 1, 1, 1, 0};
        tbl[24] = '{0, 4'b0000, 1, 4'b0000, 1, 0, 1, 0};

        @(posedge CLK); #1;

        for (int r = 0; r < 25; r++) begin
            RST       = tbl[r].rst;
            req_valid = tbl[r].vld;
            out_ready = tbl[r].ordy;
            @(negedge CLK);
            model_comb();
            chk($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
            if (tbl[r].co) begin
                chk($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tbl[r].ov));
                chk($sformatf("row%0d out_src", r), 64'(out_src), 64'(tbl[r].src));
                chk($sformatf("row%0d out_addr", r), 64'(out_addr),
                    tbl[r].zero ? 64'd0 : 64'(pa[tbl[r].src]));
                chk($sformatf("row%0d out_data", r), 64'(out_data),
                    tbl[r].zero ? 64'd0 : 64'(pd[tbl[r].src]));
            end
            @(posedge CLK);
            model_update();
            #1;
        end

        for (int c = 0; c < 400; c++) begin
            RST       = ($urandom_range(0, 39) == 0);
            req_valid = N'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            req_addr  = (N*AW)'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge CLK);
            model_comb();
            chk($sformatf("rnd%0d req_ready", c), 64'(req_ready), 64'(m_rdy));
            chk($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(m_v));
            chk($sformatf("rnd%0d out_src", c), 64'(out_src), 64'(m_src));
            chk($sformatf("rnd%0d out_addr", c), 64'(out_addr), 64'(m_addr));
            chk($sformatf("rnd%0d out_data", c), 64'(out_data), 64'(m_data));
            @(posedge CLK);
            model_update();
            #1;
        end
        RST = 1'b1;

        // NREQ=3: pointer must wrap from 2 to 0 after granting requester 2.
        RST3 = 1'b0;
        v3 = 3'b010;
        @(negedge CLK);
        chk("n3 grant1", 64'(rdy3), 64'(3'b010));
        @(posedge CLK); #1;
        v3 = 3'b100;
        @(negedge CLK);
        chk("n3 grant2", 64'(rdy3), 64'(3'b100));
        chk("n3 src1", 64'(os3), 64'd1);
        chk("n3 addr1", 64'(oa3), 64'd2);
        @(posedge CLK); #1;
        v3 = 3'b110;
        @(negedge CLK);
        chk("n3 wrap grant", 64'(rdy3), 64'(3'b010));
        chk("n3 src2", 64'(os3), 64'd2);
        chk("n3 data2", 64'(od3), 64'h2222_2222);
        @(posedge CLK); #1;
        v3 = 3'b101;
        @(negedge CLK);
        chk("n3 after wrap", 64'(rdy3), 64'(3'b100));
        @(posedge CLK); #1;
        v3 = 3'b000;
        @(negedge CLK);
        chk("n3 src last", 64'(os3), 64'd2);
        chk("n3 valid last", 64'(ov3), 64'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("n3 drained", 64'(ov3), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
